// File: rtl/dac_wave_gen.sv
// Multi-mode DAC waveform generator: prescaled sample ticks step through a
// DEPTH-entry period, build a sine/triangle/saw/square sample, attenuate it
// around mid-scale and write it to the DAC with a WE/LDAC strobe sequence.
module dac_wave_gen #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 100,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              new_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] step,
  input  logic [15:0]       div,
  input  logic [1:0]        amp_shift,
  output logic [DATA_W-1:0] to_daq,
  output logic              we_n,
  output logic              ldac_n,
  output logic              dac_rst_n,
  output logic              sample_valid,
  output logic              wrap
);

  localparam int unsigned Mid      = 2 ** (DATA_W - 1);
  localparam int unsigned Max      = 2 ** DATA_W - 1;
  localparam int unsigned Half     = DEPTH / 2;
  localparam int unsigned TriSlope = Max / Half;
  localparam int unsigned SawSlope = Max / DEPTH;
  localparam real         Pi       = 3.14159265358979323846;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StLatch = 2'd3;

  // Sine ROM, built at elaboration from the real-valued sine.
  function automatic logic [DATA_W-1:0] sine_entry(input int unsigned i);
    real phase;
    phase = 2.0 * Pi * real'(i) / real'(DEPTH);
    return DATA_W'(int'(Mid) + $rtoi($sin(phase) * real'(Mid - 1)));
  endfunction

  logic [DATA_W-1:0] sine_rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_sine
    assign sine_rom[g] = sine_entry(g);
  end

  logic [1:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       div_eff;
  logic              tick, fire;
  logic [ADDR_W-1:0] idx_q, idx_next, step_eff;
  logic [ADDR_W:0]   idx_sum;
  logic              idx_wrap;
  int unsigned       idx_u;
  logic [DATA_W-1:0] raw_d, raw_q;
  logic [1:0]        amp_q;
  logic              wrap_pend_q;
  logic signed [DATA_W:0] diff, shifted;
  logic [DATA_W-1:0] scaled;

  logic [DATA_W-1:0] to_daq_q;
  logic              we_n_q, ldac_n_q, dac_rst_n_q, valid_q, wrap_q;

  // Prescaler: counts 0..div_eff, ticks at the terminal count, parked at 0 when disabled.
  always_comb begin
    div_eff = (div < 16'd3) ? 16'd3 : div;
    tick    = en && (cnt_q >= div_eff);
    cnt_d   = cnt_q + 16'd1;
    if (!en || tick) cnt_d = '0;
  end

  // Sequencer next state; a tick is only accepted from idle.
  always_comb begin
    state_d = state_q;
    fire    = tick && (state_q == StIdle);
    unique case (state_q)
      StIdle:  if (tick) state_d = StFetch;
      StFetch: state_d = StWrite;
      StWrite: state_d = StLatch;
      StLatch: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Index advance with wrap at DEPTH; step clamped to DEPTH-1.
  always_comb begin
    step_eff = (step > ADDR_W'(DEPTH - 1)) ? ADDR_W'(DEPTH - 1) : step;
    idx_sum  = {1'b0, idx_q} + {1'b0, step_eff};
    idx_wrap = idx_sum >= (ADDR_W + 1)'(DEPTH);
    idx_next = idx_wrap ? ADDR_W'(idx_sum - (ADDR_W + 1)'(DEPTH)) : idx_sum[ADDR_W-1:0];
  end

  // Raw waveform sample from the current (pre-update) index.
  always_comb begin
    idx_u = 32'(idx_q);
    raw_d = '0;
    unique case (mode)
      2'd0: raw_d = sine_rom[idx_q];
      2'd1: raw_d = (idx_u < Half) ? DATA_W'(TriSlope * idx_u)
                                   : DATA_W'(Max - TriSlope * (idx_u - Half));
      2'd2: raw_d = DATA_W'(SawSlope * idx_u);
      2'd3: raw_d = (idx_u < Half) ? '0 : DATA_W'(Max);
      default: raw_d = '0;
    endcase
  end

  // Attenuate around mid-scale; the arithmetic shift keeps the result in range.
  always_comb begin
    diff    = $signed({1'b0, raw_q}) - $signed((DATA_W + 1)'(Mid));
    shifted = diff >>> amp_q;
    scaled  = shifted[DATA_W-1:0] + DATA_W'(Mid);
  end

  // Tick-time capture of sample, attenuation and wrap; index and prescaler state.
  always_ff @(posedge new_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      raw_q       <= DATA_W'(Mid);
      amp_q       <= '0;
      wrap_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fire) begin
        idx_q       <= idx_next;
        raw_q       <= raw_d;
        amp_q       <= amp_shift;
        wrap_pend_q <= idx_wrap;
      end
    end
  end

  // Registered DAC outputs; strobes follow the state being entered.
  always_ff @(posedge new_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_daq_q    <= DATA_W'(Mid);
      we_n_q      <= 1'b1;
      ldac_n_q    <= 1'b1;
      dac_rst_n_q <= 1'b0;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      dac_rst_n_q <= 1'b1;
      we_n_q      <= (state_d != StWrite);
      ldac_n_q    <= (state_d != StLatch);
      valid_q     <= (state_q == StFetch);
      wrap_q      <= (state_q == StFetch) && wrap_pend_q;
      if (state_q == StFetch) to_daq_q <= scaled;
    end
  end

  assign to_daq       = to_daq_q;
  assign we_n         = we_n_q;
  assign ldac_n       = ldac_n_q;
  assign dac_rst_n    = dac_rst_n_q;
  assign sample_valid = valid_q;
  assign wrap         = wrap_q;

endmodule

// File: doc/dac_wave_gen.md
# dac_wave_gen

Parametrised multi-mode waveform generator that drives the parallel DAC behind the oscilloscope (Oscar) output path. It sits between the system clock domain (`new_clk`) and the DAC pins. It produces sine, triangle, sawtooth or square samples from a DEPTH-entry period table. Sample rate is programmable through a clock prescaler, frequency through an index step, and amplitude through a right-shift scaler. Each new sample is written to the DAC with a sequenced write/latch strobe pair.

## Interface
- DATA_W, 16: DAC sample width; MID = 2^(DATA_W-1), MAX = 2^DATA_W-1.
- DEPTH, 100: samples per waveform period; must be even and at least 4.
- ADDR_W, 7: index width; must satisfy 2^ADDR_W >= DEPTH.
- new_clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  enables sample ticks.
- mode  in  2  waveform select: 0 sine, 1 triangle, 2 sawtooth, 3 square.
- step  in  ADDR_W  index increment per sample.
- div  in  16  prescaler terminal count.
- amp_shift  in  2  amplitude attenuation, 0 to 3 (0 = full scale).
- to_daq  out  DATA_W  registered DAC data bus.
- we_n  out  1  DAC write strobe, active-low.
- ldac_n  out  1  DAC load strobe, active-low.
- dac_rst_n  out  1  DAC reset, active-low.
- sample_valid  out  1  one-cycle pulse when to_daq is updated.
- wrap  out  1  one-cycle pulse, coincident with sample_valid, when this sample's index update wrapped.

## Operation
- **Prescaler**
  - div_eff = max(div, 3).
  - A counter counts 0..div_eff while en=1.
  - tick fires when count >= div_eff; the counter then returns to 0.
  - With en=0 the counter is held at 0 and no tick fires. A strobe sequence already in flight still completes, and to_daq holds its value.
- **Index**
  - step_eff = min(step, DEPTH-1).
  - On tick: idx <= idx + step_eff. If the sum is >= DEPTH, DEPTH is subtracted and a wrap flag is set for that sample.
  - step=0 holds the index, giving a constant output.
  - The sample is generated from the pre-update idx.
- **Waveforms** (i = idx, H = DEPTH/2, integer division throughout)
  - Sine: ROM entry i = MID + rtoi(sin(2πi/DEPTH)·(MID-1)), initialised at elaboration.
  - Triangle: for i<H, (MAX/H)·i; otherwise MAX - (MAX/H)·(i-H).
  - Sawtooth: (MAX/DEPTH)·i.
  - Square: 0 for i<H, MAX otherwise.
- **Mode sampling**
  - mode, step and amp_shift are sampled at tick.
  - A change takes effect on the next sample and does not reset idx.
- **Scaling**
  - d = raw - MID, computed as a (DATA_W+1)-bit signed value.
  - out = MID + (d >>> amp_shift), an arithmetic shift.
  - The result always fits in DATA_W bits, so no saturation logic is needed.
- **Sequencer FSM** (IDLE, FETCH, WRITE, LATCH)
  - IDLE goes to FETCH on tick; the raw sample is registered in FETCH.
  - FETCH goes to WRITE unconditionally.
  - LATCH goes to IDLE unconditionally.
  - Ticks arriving outside IDLE cannot occur, because div_eff >= 3.

## Timing
- Tick in cycle T:
  - T+1 (FETCH): the raw sample is registered.
  - T+2 (WRITE): to_daq is valid, we_n=0, sample_valid=1, and wrap=1 if the index wrapped.
  - T+3 (LATCH): ldac_n=0, with to_daq stable.
  - T+4: back to IDLE, all strobes high.
- Tick-to-data latency is 2 clocks. Sample period is div_eff+1 clocks.
- After reset release with en=1, the first tick fires in clock cycle div_eff (0-based), and its sample comes from idx 0.
- **Reset values** (applied asynchronously while rst_n=0):
  - to_daq = MID; we_n = 1; ldac_n = 1; dac_rst_n = 0.
  - sample_valid = 0; wrap = 0.
  - idx = 0; prescaler = 0; FSM = IDLE.
- dac_rst_n rises on the first clock edge after reset release.
- **Reset mid-sequence:** strobes return high immediately and the sample is discarded. No partial ldac pulse is allowed.
- **div change:** if the counter is already at or above the new div_eff, tick fires next cycle.
- All outputs are registered, with no combinational paths from inputs.

## Test plan
- **Reset values:** hold rst_n=0 for 5 clocks -> to_daq=0x8000, we_n=1, ldac_n=1, dac_rst_n=0. Release -> dac_rst_n=1 after one edge.
- **Sine, full rate:** mode=0, step=1, div=3, amp_shift=0 -> samples 1, 26 and 76 are 0x8000, 0xFFFF and 0x0001. we_n is low one cycle every 4 clocks, with ldac_n low the following cycle. wrap is asserted with samples 100, 200, ...
- **Sawtooth, step and wrap:** mode=2, step=25 -> to_daq sequence 0, 16375, 32750, 49125, repeating, with wrap on every 4th sample.
- **Triangle and square:** triangle with step=25 -> 0, 32750, 65535, 32785. Square with step=50 -> alternating 0x0000 / 0xFFFF.
- **Div clamp and scaling:** div=0 -> sample period is 4 clocks. Sine with amp_shift=1 -> idx25 gives 49151 and idx75 gives 16384.
- **Reset and en mid-operation:** assert rst_n low during WRITE -> we_n=1 in the same cycle and to_daq=0x8000. Separately, drop en during FETCH -> WRITE and LATCH still occur, then no further sample_valid and to_daq holds.
